// File: rtl/irrigation_timer_controller.sv
// irrigation_timer_controller
//   Timed valve controller. A start request loads the preset for the selected
//   mode (drip or sprinkler) as MM:00 in BCD. The counter then counts down once
//   per second_tick while the valve is open. On reaching 00:00 the block parks
//   in DONE until irrigation_on drops. Any sensor conflict forces FAULT, which
//   is left only once the conflict has cleared and irrigation_on is low.
//
// Ports
//   clock              system clock, rising edge
//   reset              synchronous, active-high
//   second_tick        one-cycle pulse per second
//   irrigation_on      level, irrigation requested
//   irrigation_mode    level, 0 = drip, 1 = sprinkler
//   stop_button_n      level, active-low operator stop
//   conflicting_values level, sensor inconsistency
//   minutes_d/_u       BCD minutes tens/units
//   seconds_d/_u       BCD seconds tens/units
//   valve_open         high exactly while RUNNING
//   done               one-cycle pulse on the first cycle in DONE
//   state              IDLE=00 RUNNING=01 DONE=10 FAULT=11
module irrigation_timer_controller #(
  parameter int DRIP_MINUTES      = 30,
  parameter int SPRINKLER_MINUTES = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       second_tick,
  input  logic       irrigation_on,
  input  logic       irrigation_mode,
  input  logic       stop_button_n,
  input  logic       conflicting_values,
  output logic [1:0] minutes_d,
  output logic [3:0] minutes_u,
  output logic [2:0] seconds_d,
  output logic [3:0] seconds_u,
  output logic       valve_open,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_DONE    = 2'b10,
    S_FAULT   = 2'b11
  } state_t;

  // Presets split into BCD digits at elaboration time (legal range 1..39).
  localparam logic [1:0] DRIP_MD = 2'(DRIP_MINUTES / 10);
  localparam logic [3:0] DRIP_MU = 4'(DRIP_MINUTES % 10);
  localparam logic [1:0] SPR_MD  = 2'(SPRINKLER_MINUTES / 10);
  localparam logic [3:0] SPR_MU  = 4'(SPRINKLER_MINUTES % 10);

  state_t     st_q, st_d;
  logic [1:0] md_q, md_d;
  logic [3:0] mu_q, mu_d;
  logic [2:0] sd_q, sd_d;
  logic [3:0] su_q, su_d;
  logic       valve_q, valve_d;
  logic       done_q, done_d;
  logic       mode_q;

  logic [1:0] preset_md;
  logic [3:0] preset_mu;
  logic       mode_change;
  logic       at_one;
  logic       at_zero;

  assign preset_md   = irrigation_mode ? SPR_MD : DRIP_MD;
  assign preset_mu   = irrigation_mode ? SPR_MU : DRIP_MU;
  assign mode_change = irrigation_mode != mode_q;
  assign at_zero     = (md_q == 2'd0) && (mu_q == 4'd0) && (sd_q == 3'd0) && (su_q == 4'd0);
  assign at_one      = (md_q == 2'd0) && (mu_q == 4'd0) && (sd_q == 3'd0) && (su_q == 4'd1);

  always_comb begin
    st_d   = st_q;
    md_d   = md_q;
    mu_d   = mu_q;
    sd_d   = sd_q;
    su_d   = su_q;
    done_d = 1'b0;

    unique case (st_q)
      S_IDLE: begin
        // Counter already sits at 00:00 here; ticks are ignored.
        if (conflicting_values) begin
          st_d = S_FAULT;
          {md_d, mu_d, sd_d, su_d} = '0;
        end else if (irrigation_on && stop_button_n) begin
          // Load on the start edge; a tick on this same edge is dropped.
          st_d = S_RUNNING;
          md_d = preset_md;
          mu_d = preset_mu;
          sd_d = 3'd0;
          su_d = 4'd0;
        end
      end

      S_RUNNING: begin
        if (conflicting_values) begin
          st_d = S_FAULT;
          {md_d, mu_d, sd_d, su_d} = '0;
        end else if (!stop_button_n || !irrigation_on) begin
          st_d = S_IDLE;
          {md_d, mu_d, sd_d, su_d} = '0;
        end else if (mode_change) begin
          // Reload wins over a coincident tick.
          md_d = preset_md;
          mu_d = preset_mu;
          sd_d = 3'd0;
          su_d = 4'd0;
        end else if (second_tick) begin
          if (at_one) begin
            st_d   = S_DONE;
            done_d = 1'b1;
            {md_d, mu_d, sd_d, su_d} = '0;
          end else if (!at_zero) begin
            // BCD borrow chain, seconds units up through minutes tens.
            if (su_q != 4'd0) begin
              su_d = su_q - 4'd1;
            end else begin
              su_d = 4'd9;
              if (sd_q != 3'd0) begin
                sd_d = sd_q - 3'd1;
              end else begin
                sd_d = 3'd5;
                if (mu_q != 4'd0) begin
                  mu_d = mu_q - 4'd1;
                end else begin
                  mu_d = 4'd9;
                  md_d = md_q - 2'd1;
                end
              end
            end
          end
        end
      end

      S_DONE: begin
        {md_d, mu_d, sd_d, su_d} = '0;
        if (conflicting_values)  st_d = S_FAULT;
        else if (!irrigation_on) st_d = S_IDLE;
      end

      S_FAULT: begin
        {md_d, mu_d, sd_d, su_d} = '0;
        if (!conflicting_values && !irrigation_on) st_d = S_IDLE;
      end

      default: begin
        st_d = S_IDLE;
        {md_d, mu_d, sd_d, su_d} = '0;
      end
    endcase

    valve_d = (st_d == S_RUNNING);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= S_IDLE;
      md_q    <= '0;
      mu_q    <= '0;
      sd_q    <= '0;
      su_q    <= '0;
      valve_q <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      md_q    <= md_d;
      mu_q    <= mu_d;
      sd_q    <= sd_d;
      su_q    <= su_d;
      valve_q <= valve_d;
      done_q  <= done_d;
      mode_q  <= irrigation_mode;
    end
  end

  assign minutes_d  = md_q;
  assign minutes_u  = mu_q;
  assign seconds_d  = sd_q;
  assign seconds_u  = su_q;
  assign valve_open = valve_q;
  assign done       = done_q;
  assign state      = st_q;

endmodule

// File: tb/tb_irrigation_timer_controller.sv
// Directed bench. Two instances share stimulus: "a" uses the default presets
// (30/15 min), "b" uses SPRINKLER_MINUTES=1 for the full-countdown case.
module tb_irrigation_timer_controller;

  logic clock = 1'b0;
  logic reset, second_tick, irrigation_on, irrigation_mode, stop_button_n, conflicting_values;

  logic [1:0] a_md, b_md;
  logic [3:0] a_mu, b_mu;
  logic [2:0] a_sd, b_sd;
  logic [3:0] a_su, b_su;
  logic       a_valve, b_valve, a_done, b_done;
  logic [1:0] a_state, b_state;

  irrigation_timer_controller dut_a (
    .clock(clock), .reset(reset), .second_tick(second_tick),
    .irrigation_on(irrigation_on), .irrigation_mode(irrigation_mode),
    .stop_button_n(stop_button_n), .conflicting_values(conflicting_values),
    .minutes_d(a_md), .minutes_u(a_mu), .seconds_d(a_sd), .seconds_u(a_su),
    .valve_open(a_valve), .done(a_done), .state(a_state)
  );

  irrigation_timer_controller #(.DRIP_MINUTES(30), .SPRINKLER_MINUTES(1)) dut_b (
    .clock(clock), .reset(reset), .second_tick(second_tick),
    .irrigation_on(irrigation_on), .irrigation_mode(irrigation_mode),
    .stop_button_n(stop_button_n), .conflicting_values(conflicting_values),
    .minutes_d(b_md), .minutes_u(b_mu), .seconds_d(b_sd), .seconds_u(b_su),
    .valve_open(b_valve), .done(b_done), .state(b_state)
  );

  always #5 clock = ~clock;

  logic [12:0] cnt_a, cnt_b;
  assign cnt_a = {a_md, a_mu, a_sd, a_su};
  assign cnt_b = {b_md, b_mu, b_sd, b_su};

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  function automatic logic [12:0] bcd(input int m, input int s);
    return {2'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge; inputs change there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    second_tick = 1'b1;
    repeat (n) step();
    second_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; second_tick = 1'b0; irrigation_on = 1'b0; irrigation_mode = 1'b0;
    stop_button_n = 1'b1; conflicting_values = 1'b0;
    step(); step();
    chk("rst_state", 16'(a_state), 16'd0);
    chk("rst_cnt",   16'(cnt_a),   16'(bcd(0, 0)));
    chk("rst_valve", 16'(a_valve), 16'd0);
    chk("rst_done",  16'(a_done),  16'd0);
    reset = 1'b0;

    // Start in drip with a tick on the start edge: tick must be ignored.
    irrigation_on = 1'b1; second_tick = 1'b1;
    step();
    chk("start_state", 16'(a_state), 16'd1);
    chk("start_valve", 16'(a_valve), 16'd1);
    chk("start_cnt",   16'(cnt_a),   16'(bcd(30, 0)));
    ticks(3);
    chk("drip_3ticks", 16'(cnt_a), 16'(bcd(29, 57)));
    ticks(7);
    chk("drip_2950", 16'(cnt_a), 16'(bcd(29, 50)));

    // Mode change with a simultaneous tick: reload, tick dropped.
    irrigation_mode = 1'b1; second_tick = 1'b1;
    step();
    second_tick = 1'b0;
    chk("mode_reload_cnt",   16'(cnt_a),   16'(bcd(15, 0)));
    chk("mode_reload_state", 16'(a_state), 16'd1);
    step();
    chk("mode_settled", 16'(cnt_a), 16'(bcd(15, 0)));

    // Borrow chain.
    ticks(1);
    chk("borrow_1459", 16'(cnt_a), 16'(bcd(14, 59)));
    ticks(299);
    chk("cnt_1000", 16'(cnt_a), 16'(bcd(10, 0)));
    ticks(1);
    chk("borrow_0959", 16'(cnt_a), 16'(bcd(9, 59)));

    // One-cycle stop pulse.
    stop_button_n = 1'b0;
    step();
    stop_button_n = 1'b1;
    chk("stop_state", 16'(a_state), 16'd0);
    chk("stop_cnt",   16'(cnt_a),   16'(bcd(0, 0)));
    chk("stop_valve", 16'(a_valve), 16'd0);
    // irrigation_on still high: a fresh start follows.
    step();
    chk("restart_state", 16'(a_state), 16'd1);
    chk("restart_cnt",   16'(cnt_a),   16'(bcd(15, 0)));

    // Conflict beats stop in the same cycle.
    conflicting_values = 1'b1; stop_button_n = 1'b0;
    step();
    chk("fault_state", 16'(a_state), 16'd3);
    chk("fault_cnt",   16'(cnt_a),   16'(bcd(0, 0)));
    chk("fault_valve", 16'(a_valve), 16'd0);
    conflicting_values = 1'b0; stop_button_n = 1'b1;
    step();
    chk("fault_hold_on", 16'(a_state), 16'd3);
    irrigation_on = 1'b0;
    step();
    chk("fault_exit", 16'(a_state), 16'd0);

    // Reset mid-run at 12:34.
    irrigation_on = 1'b1;
    step();
    ticks(146);
    chk("cnt_1234", 16'(cnt_a), 16'(bcd(12, 34)));
    reset = 1'b1; second_tick = 1'b1;
    step();
    reset = 1'b0; second_tick = 1'b0;
    chk("midrst_state", 16'(a_state), 16'd0);
    chk("midrst_cnt",   16'(cnt_a),   16'(bcd(0, 0)));
    chk("midrst_done",  16'(a_done),  16'd0);
    chk("midrst_valve", 16'(a_valve), 16'd0);
    step();
    chk("post_rst_start", 16'(cnt_a), 16'(bcd(15, 0)));

    // Full countdown on the 1-minute sprinkler instance.
    irrigation_on = 1'b0;
    step();
    chk("b_idle", 16'(b_state), 16'd0);
    irrigation_on = 1'b1;
    step();
    chk("b_start_cnt", 16'(cnt_b), 16'(bcd(1, 0)));
    ticks(59);
    chk("b_0001_cnt",   16'(cnt_b),   16'(bcd(0, 1)));
    chk("b_0001_state", 16'(b_state), 16'd1);
    ticks(1);
    chk("b_end_cnt",   16'(cnt_b),   16'(bcd(0, 0)));
    chk("b_end_state", 16'(b_state), 16'd2);
    chk("b_end_done",  16'(b_done),  16'd1);
    chk("b_end_valve", 16'(b_valve), 16'd0);
    step();
    chk("b_done_pulse", 16'(b_done),  16'd0);
    chk("b_done_hold",  16'(b_state), 16'd2);
    ticks(1);
    chk("b_done_tick_state", 16'(b_state), 16'd2);
    chk("b_done_tick_cnt",   16'(cnt_b),   16'(bcd(0, 0)));
    conflicting_values = 1'b1;
    step();
    chk("b_done_fault", 16'(b_state), 16'd3);
    conflicting_values = 1'b0; irrigation_on = 1'b0;
    step();
    chk("b_fault_exit", 16'(b_state), 16'd0);
    conflicting_values = 1'b1;
    step();
    chk("b_idle_fault", 16'(b_state), 16'd3);
    conflicting_values = 1'b0;
    step();
    chk("b_idle_back", 16'(b_state), 16'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
